// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check master:
//   - state_e         : sequencing FSM states (3-bit encoding)
//   - SYSID_ADDR_ID   : word address of the system ID in the sysid slave
//   - SYSID_ADDR_TS   : word address of the generation timestamp
//   - TIMEOUT_CNT_W   : width of the per-phase timeout counter
// -----------------------------------------------------------------------------
package sysid_check_pkg;

  localparam int   TIMEOUT_CNT_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/sysid_check_master_if.sv
// -----------------------------------------------------------------------------
// sysid_check_master_if
// Avalon-MM read-only bus between the check master and the sysid slave.
//   avm_address        master -> slave  word address (0 = ID, 1 = timestamp)
//   avm_read           master -> slave  read request
//   avm_readdata       slave  -> master 32-bit read data
//   avm_waitrequest    slave  -> master stall, request must be held
//   avm_readdatavalid  slave  -> master qualifies avm_readdata
// Modports: master (the check block), slave (the sysid peripheral / model).
// -----------------------------------------------------------------------------
interface sysid_check_master_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest,
    output avm_readdatavalid
  );

endinterface

// File: rtl/avm_single_read.sv
// -----------------------------------------------------------------------------
// avm_single_read
// Handshake and timeout logic for one Avalon-MM single-word read. Time-shared
// by the ID and timestamp phases; the owning FSM says which part of the phase
// it is in and clears the counter when a new request phase starts.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   clear           restart the phase timeout counter (entry to a REQ state)
//   req_phase       owner is in a REQ state (request must be driven)
//   wait_phase      owner is in a WAIT state (request accepted, awaiting data)
//   waitrequest     slave stall
//   readdatavalid   slave data qualifier
//   read            avm_read to the slave
//   accepted        request taken by the slave this cycle
//   captured        read data is valid and belongs to this phase
//   timed_out       phase hit TIMEOUT_CYCLES; abort
// -----------------------------------------------------------------------------
module avm_single_read
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic req_phase,
  input  logic wait_phase,
  input  logic waitrequest,
  input  logic readdatavalid,
  output logic read,
  output logic accepted,
  output logic captured,
  output logic timed_out
);

  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

  logic                     active;
  logic [TIMEOUT_CNT_W-1:0] cnt;

  assign active = req_phase | wait_phase;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + TIMEOUT_CNT_W'(1);
    end
  end

  // The timeout cycle itself drops the request so nothing new is accepted
  // while the owner is heading to FIN.
  assign timed_out = active && (cnt == TIMEOUT_LIMIT);
  assign read      = req_phase && !timed_out;
  assign accepted  = read && !waitrequest;
  // Data is only ours in a WAIT state or in the accept cycle itself
  // (zero-latency slave); a stray readdatavalid elsewhere is ignored.
  assign captured  = readdatavalid && !timed_out && (accepted || wait_phase);

endmodule

// File: rtl/sysid_check_master.sv
// -----------------------------------------------------------------------------
// sysid_check_master
// Avalon-MM read master that reads the system-ID slave (word 0 = ID, word 1 =
// generation timestamp), compares both against the build's expected values
// and reports the outcome through sticky status flags.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   start              one-cycle pulse launching a check (ignored while busy)
//   avm                Avalon-MM master modport (address/read/readdata/
//                      waitrequest/readdatavalid)
//   id_value           captured word 0
//   timestamp_value    captured word 1
//   busy               check in progress
//   done               check finished, sticky until the next start
//   id_ok              id_value matched EXPECTED_ID
//   timestamp_ok       timestamp_value matched EXPECTED_TIMESTAMP
//   timeout_err        a read phase ran for TIMEOUT_CYCLES without completing
// Build option:
//   SYSID_AUTOSTART_EN defined: one check launches automatically on the first
//   clock edge after reset release; start still works afterwards.
// -----------------------------------------------------------------------------
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1575193418,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic [31:0]                 id_value,
  output logic [31:0]                 timestamp_value,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        timestamp_ok,
  output logic                        timeout_err
);

  state_e state, state_nxt;
  logic   launch;
  logic   req_phase, wait_phase, ts_phase;
  logic   phase_clear;
  logic   rd_read, rd_accepted, rd_captured, rd_timed_out;
  logic   id_match, ts_match;

`ifdef SYSID_AUTOSTART_EN
  // Set by reset, so it is high for exactly the first edge after release.
  logic auto_pend;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_pend <= 1'b1;
    else          auto_pend <= 1'b0;
  end

  assign launch = start | auto_pend;
`else
  assign launch = start;
`endif

  assign req_phase  = (state == ST_REQ_ID)  || (state == ST_REQ_TS);
  assign wait_phase = (state == ST_WAIT_ID) || (state == ST_WAIT_TS);
  assign ts_phase   = (state == ST_REQ_TS)  || (state == ST_WAIT_TS);

  // REQ states only self-loop, so "next is REQ and current is not" marks entry.
  assign phase_clear = ((state_nxt == ST_REQ_ID) && (state != ST_REQ_ID)) ||
                       ((state_nxt == ST_REQ_TS) && (state != ST_REQ_TS));

  avm_single_read #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (phase_clear),
    .req_phase     (req_phase),
    .wait_phase    (wait_phase),
    .waitrequest   (avm.avm_waitrequest),
    .readdatavalid (avm.avm_readdatavalid),
    .read          (rd_read),
    .accepted      (rd_accepted),
    .captured      (rd_captured),
    .timed_out     (rd_timed_out)
  );

  // Derived from registered state, so reset drops avm_read asynchronously.
  assign avm.avm_read    = rd_read;
  assign avm.avm_address = ts_phase ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (launch) state_nxt = ST_REQ_ID;
      ST_REQ_ID: begin
        if      (rd_timed_out) state_nxt = ST_FIN;
        else if (rd_captured)  state_nxt = ST_REQ_TS;
        else if (rd_accepted)  state_nxt = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        if      (rd_timed_out) state_nxt = ST_FIN;
        else if (rd_captured)  state_nxt = ST_REQ_TS;
      end
      ST_REQ_TS: begin
        if      (rd_timed_out) state_nxt = ST_FIN;
        else if (rd_captured)  state_nxt = ST_FIN;
        else if (rd_accepted)  state_nxt = ST_WAIT_TS;
      end
      ST_WAIT_TS: begin
        if (rd_timed_out || rd_captured) state_nxt = ST_FIN;
      end
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value        <= '0;
      timestamp_value <= '0;
      id_match        <= 1'b0;
      ts_match        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      timestamp_ok    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && launch) begin
        busy         <= 1'b1;
        done         <= 1'b0;
        id_ok        <= 1'b0;
        timestamp_ok <= 1'b0;
        timeout_err  <= 1'b0;
        id_match     <= 1'b0;
        ts_match     <= 1'b0;
      end

      // Compares are registered at capture so FIN only forwards flops.
      if (rd_captured && !ts_phase) begin
        id_value <= avm.avm_readdata;
        id_match <= (avm.avm_readdata == EXPECTED_ID);
      end
      if (rd_captured && ts_phase) begin
        timestamp_value <= avm.avm_readdata;
        ts_match        <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
      end

      if (rd_timed_out) timeout_err <= 1'b1;

      // A timed-out check never reports ok, even if a stale match is held.
      if (state == ST_FIN) begin
        busy         <= 1'b0;
        done         <= 1'b1;
        id_ok        <= id_match && !timeout_err;
        timestamp_ok <= ts_match && !timeout_err;
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_master
// Directed bench for sysid_check_master with a behavioural sysid slave model
// (configurable waitrequest stall, wrong data, missing readdatavalid) and
// scoreboard queues for expected read addresses and expected check results.
// Honours SYSID_AUTOSTART_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1575193418;
  localparam int          TMO    = 8;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        timestamp_ok;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;

  exp_t        exp_q[$];
  logic        addr_q[$];

  // slave model configuration and state
  int          cfg_wait     = 0;
  bit          cfg_drop_id  = 1'b0;
  logic [31:0] cfg_id_data  = EXP_ID;
  logic [31:0] cfg_ts_data  = EXP_TS;
  bit          s_in_req     = 1'b0;
  bit          s_pend       = 1'b0;
  int          s_stall      = 0;
  logic        s_addr       = 1'b0;
  logic [31:0] s_pend_data  = '0;

  sysid_check_master_if avm ();

  sysid_check_master #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm             (avm),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .timestamp_ok    (timestamp_ok),
    .timeout_err     (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Slave model: drives on the falling edge, DUT samples on the rising edge.
  always @(negedge clock) begin
    avm.avm_readdatavalid = 1'b0;
    avm.avm_waitrequest   = 1'b0;
    if (!reset_n) begin
      s_in_req = 1'b0;
      s_pend   = 1'b0;
      s_stall  = 0;
    end else begin
      if (s_pend) begin
        avm.avm_readdatavalid = 1'b1;
        avm.avm_readdata      = s_pend_data;
        s_pend                = 1'b0;
      end
      if (avm.avm_read === 1'b1) begin
        if (!s_in_req) begin
          s_in_req = 1'b1;
          s_stall  = cfg_wait;
          s_addr   = avm.avm_address;
        end else begin
          check("addr_stable", avm.avm_address, s_addr);
        end
        if (s_stall > 0) begin
          avm.avm_waitrequest = 1'b1;
          s_stall--;
        end else begin
          s_in_req = 1'b0;
          check("read_expected", addr_q.size() > 0, 1'b1);
          if (addr_q.size() > 0) check("read_addr", avm.avm_address, addr_q.pop_front());
          if (!(cfg_drop_id && avm.avm_address == 1'b0)) begin
            s_pend      = 1'b1;
            s_pend_data = avm.avm_address ? cfg_ts_data : cfg_id_data;
          end
        end
      end else if (s_in_req) begin
        check("read_held", avm.avm_read, 1'b1);
      end
    end
  end

  task automatic expect_run(input logic to, input logic [31:0] id, input logic [31:0] ts,
                            input int lat, input bit ts_read);
    exp_t e;
    e.id    = id;
    e.ts    = ts;
    e.to    = to;
    e.id_ok = !to && (id == EXP_ID);
    e.ts_ok = !to && (ts == EXP_TS);
    e.lat   = lat;
    exp_q.push_back(e);
    addr_q.push_back(1'b0);
    if (ts_read) addr_q.push_back(1'b1);
  endtask

  // Called #1 after the edge that sampled the launch; counts edges to done.
  task automatic finish_run(input int extra_start);
    int   n   = 0;
    bit   got = 1'b0;
    exp_t e;
    check("busy_after_start", busy, 1'b1);
    while (!got && n < 80) begin
      @(posedge clock);
      #1;
      n++;
      start = (extra_start > 0) && (n == extra_start);
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    check("exp_pending", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("latency", n, e.lat);
      check("busy_at_done", busy, 1'b0);
      check("id_value", id_value, e.id);
      check("timestamp_value", timestamp_value, e.ts);
      check("id_ok", id_ok, e.id_ok);
      check("timestamp_ok", timestamp_ok, e.ts_ok);
      check("timeout_err", timeout_err, e.to);
      check("read_low_at_done", avm.avm_read, 1'b0);
      check("reads_consumed", addr_q.size(), 0);
    end
    if (extra_start > 0) begin
      @(posedge clock);
      #1;
      check("restart_ignored", busy, 1'b0);
      check("done_sticky", done, 1'b1);
    end
  endtask

  task automatic launch(input int extra_start);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    finish_run(extra_start);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_id_ok"}, id_ok, 1'b0);
    check({pfx, "_ts_ok"}, timestamp_ok, 1'b0);
    check({pfx, "_timeout"}, timeout_err, 1'b0);
    check({pfx, "_read"}, avm.avm_read, 1'b0);
    check({pfx, "_addr"}, avm.avm_address, 1'b0);
    check({pfx, "_id_value"}, id_value, 32'h0);
    check({pfx, "_ts_value"}, timestamp_value, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");

`ifdef SYSID_AUTOSTART_EN
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    finish_run(0);
`else
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("no_autostart_busy", busy, 1'b0);
    check("no_autostart_read", avm.avm_read, 1'b0);
`endif

    // zero-wait, 1-cycle latency slave: minimum latency pass
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    launch(0);

    // three waitrequest cycles per request: six cycles later, still passes
    cfg_wait = 3;
    expect_run(1'b0, EXP_ID, EXP_TS, 11, 1'b1);
    launch(0);
    cfg_wait = 0;

    // wrong timestamp
    cfg_ts_data = EXP_TS + 32'd1;
    expect_run(1'b0, EXP_ID, EXP_TS + 32'd1, 5, 1'b1);
    launch(0);

    // no data for word 0: timeout, no word-1 read, values kept
    cfg_drop_id = 1'b1;
    expect_run(1'b1, EXP_ID, EXP_TS + 32'd1, TMO + 2, 1'b0);
    launch(0);
    cfg_drop_id = 1'b0;
    cfg_ts_data = EXP_TS;

    // start pulsed again mid-check must be ignored
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    launch(2);

    // reset asserted in WAIT_TS: outputs return to zero without a clock edge
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("wait_ts_busy", busy, 1'b1);
    check("wait_ts_addr", avm.avm_address, 1'b1);
    check("wait_ts_read", avm.avm_read, 1'b0);
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

`ifdef SYSID_AUTOSTART_EN
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    @(posedge clock);
    #1;
    finish_run(0);
`endif

    // recovery after reset
    expect_run(1'b0, EXP_ID, EXP_TS, 5, 1'b1);
    launch(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
